frame_disassembly: RTL and testbench

Receive-side counterpart of the MHP frame transmitter: consumes an MHP byte stream and deserialises header fields and payload. Verifies the 16-bit shifted-sum checksum (SCS) and presents a decoded frame with a one-cycle valid pulse. Sits between the byte-level link receiver and the protocol/command layer.

---
 rtl/mhp_pkg.sv | 30 +++
 rtl/mhp_scs_acc.sv | 53 +++++
 rtl/frame_disassembly.sv | 235 +++++++++++++++++++++++
 tb/tb_frame_disassembly.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mhp_pkg.sv
// Shared MHP definitions used by the frame transmitter and receiver.
// Contents: frame length constants, receiver state encoding, error codes and
// the SCS per-byte term helper.
package mhp_pkg;

  localparam int unsigned MHP_HDR_LEN     = 7;
  localparam int unsigned MHP_MAX_PAYLOAD = 42;
  localparam int unsigned MHP_SCS_LEN     = 2;
  localparam int unsigned MHP_FRAME_LEN   = 51;

  // Receiver state encoding
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t StIdle    = 3'd0;
  localparam rx_state_t StHeader  = 3'd1;
  localparam rx_state_t StPayload = 3'd2;
  localparam rx_state_t StScs     = 3'd3;
  localparam rx_state_t StDiscard = 3'd4;

  // Error codes reported on o_err_code
  localparam logic [1:0] ErrNone = 2'd0;
  localparam logic [1:0] ErrScs  = 2'd1;
  localparam logic [1:0] ErrSize = 2'd2;
  localparam logic [1:0] ErrGap  = 2'd3;

  // One SCS term: the byte zero-extended to 16 bits and shifted by its phase.
  function automatic logic [15:0] scs_term(input logic [7:0] b, input logic [1:0] sh);
    return 16'(b) << sh;
  endfunction

endpackage

// File: rtl/mhp_scs_acc.sv
// MHP shifted-sum checksum accumulator. Each accepted byte is added shifted
// left by a 2-bit phase that rotates 0,1,2,3 from the first byte of a frame.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   clear_i  restart the sum; with en_i set, byte_i becomes the first term
//   en_i     accumulate byte_i this cycle
//   byte_i   byte to accumulate
//   sum_o    running 16-bit sum of all bytes accepted since the last clear
module mhp_scs_acc
  import mhp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] sum_o
);

  logic [15:0] sum_q, sum_d;
  logic [1:0]  phase_q, phase_d;

  always_comb begin
    sum_d   = sum_q;
    phase_d = phase_q;
    if (en_i) begin
      if (clear_i) begin
        sum_d   = scs_term(byte_i, 2'd0);
        phase_d = 2'd1;
      end else begin
        sum_d   = sum_q + scs_term(byte_i, phase_q);
        phase_d = phase_q + 2'd1;
      end
    end else if (clear_i) begin
      sum_d   = '0;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q   <= '0;
      phase_q <= '0;
    end else begin
      sum_q   <= sum_d;
      phase_q <= phase_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/frame_disassembly.sv
// MHP frame receiver: deserialises header fields and payload from a byte
// stream, optionally verifies the SCS, and presents a decoded frame with a
// one-cycle o_valid pulse. Dropped frames pulse o_err with a code.
// Optional feature macro: FRAME_DISASSEMBLY_SCS_CHECK_EN enables the SCS
// accumulator and comparison; without it the SCS bytes are skipped.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_rdata, i_rvalid     received byte and its valid strobe (no backpressure)
//   o_dst, o_src, o_size  decoded header fields
//   o_dir, o_type         direction bit and frame type
//   o_payload             payload, byte i at [8i+7:8i], unused bytes zero
//   o_payload_size        payload byte count
//   o_valid, o_err        one-cycle frame-good / frame-dropped pulses
//   o_err_code            last error code (0 until the first error)
module frame_disassembly
  import mhp_pkg::*;
#(
  parameter int unsigned GAP_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   i_rdata,
  input  logic         i_rvalid,
  output logic [15:0]  o_dst,
  output logic [15:0]  o_src,
  output logic [15:0]  o_size,
  output logic         o_dir,
  output logic [6:0]   o_type,
  output logic [335:0] o_payload,
  output logic [5:0]   o_payload_size,
  output logic         o_valid,
  output logic         o_err,
  output logic [1:0]   o_err_code
);

  localparam logic [7:0]  GapLast = 8'(GAP_TIMEOUT - 1);
  localparam logic [15:0] MaxSize = 16'(MHP_MAX_PAYLOAD);

  rx_state_t      state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [7:0]     gap_q, gap_d;
  // Working registers for the frame being received
  logic [15:0]    dst_q, dst_d, src_q, src_d, size_q, size_d;
  logic [7:0]     dt_q, dt_d;
  logic [335:0]   pay_q, pay_d;
  // Output registers
  logic [15:0]    out_dst_q, out_dst_d, out_src_q, out_src_d, out_size_q, out_size_d;
  logic [7:0]     out_dt_q, out_dt_d;
  logic [335:0]   out_pay_q, out_pay_d;
  logic           valid_q, valid_d, err_q, err_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           scs_ok;

`ifdef FRAME_DISASSEMBLY_SCS_CHECK_EN
  logic        acc_clr, acc_en;
  logic [15:0] acc_sum;
  logic [7:0]  scs_lo_q;

  // Header and payload bytes feed the sum; the first byte of a frame restarts it.
  always_comb begin
    acc_clr = i_rvalid && (state_q == StIdle);
    acc_en  = i_rvalid && ((state_q == StIdle) || (state_q == StHeader) ||
                           (state_q == StPayload));
  end

  mhp_scs_acc u_scs_acc (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (acc_clr),
    .en_i    (acc_en),
    .byte_i  (i_rdata),
    .sum_o   (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      scs_lo_q <= '0;
    end else if (i_rvalid && (state_q == StScs) && (cnt_q == '0)) begin
      scs_lo_q <= i_rdata;
    end
  end

  // Only meaningful while the high SCS byte is on i_rdata
  assign scs_ok = ({i_rdata, scs_lo_q} == acc_sum);
`else
  assign scs_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    dst_d      = dst_q;
    src_d      = src_q;
    size_d     = size_q;
    dt_d       = dt_q;
    pay_d      = pay_q;
    out_dst_d  = out_dst_q;
    out_src_d  = out_src_q;
    out_size_d = out_size_q;
    out_dt_d   = out_dt_q;
    out_pay_d  = out_pay_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    if (i_rvalid) begin
      gap_d = '0;
      case (state_q)
        StIdle: begin
          dst_d[7:0] = i_rdata;
          pay_d      = '0;
          cnt_d      = 6'd1;
          state_d    = StHeader;
        end
        StHeader: begin
          cnt_d = cnt_q + 6'd1;
          case (cnt_q)
            6'd1: dst_d[15:8]  = i_rdata;
            6'd2: src_d[7:0]   = i_rdata;
            6'd3: src_d[15:8]  = i_rdata;
            6'd4: size_d[15:8] = i_rdata;
            6'd5: size_d[7:0]  = i_rdata;
            default: begin
              // Last header byte; size is complete in size_q
              dt_d  = i_rdata;
              cnt_d = '0;
              if (size_q > MaxSize) begin
                err_d      = 1'b1;
                err_code_d = ErrSize;
                state_d    = StDiscard;
              end else if (size_q == '0) begin
                state_d = StScs;
              end else begin
                state_d = StPayload;
              end
            end
          endcase
        end
        StPayload: begin
          pay_d[{cnt_q, 3'b000} +: 8] = i_rdata;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == size_q[5:0] - 6'd1) begin
            cnt_d   = '0;
            state_d = StScs;
          end
        end
        StScs: begin
          if (cnt_q == '0) begin
            cnt_d = 6'd1;
          end else begin
            cnt_d   = '0;
            state_d = StIdle;
            if (scs_ok) begin
              valid_d    = 1'b1;
              out_dst_d  = dst_q;
              out_src_d  = src_q;
              out_size_d = size_q;
              out_dt_d   = dt_q;
              out_pay_d  = pay_q;
            end else begin
              err_d      = 1'b1;
              err_code_d = ErrScs;
            end
          end
        end
        StDiscard: ;
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (gap_q == GapLast) begin
        state_d = StIdle;
        gap_d   = '0;
        cnt_d   = '0;
        // Discard already reported its error when it was entered
        if (state_q != StDiscard) begin
          err_d      = 1'b1;
          err_code_d = ErrGap;
        end
      end else begin
        gap_d = gap_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      gap_q      <= '0;
      dst_q      <= '0;
      src_q      <= '0;
      size_q     <= '0;
      dt_q       <= '0;
      pay_q      <= '0;
      out_dst_q  <= '0;
      out_src_q  <= '0;
      out_size_q <= '0;
      out_dt_q   <= '0;
      out_pay_q  <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      dst_q      <= dst_d;
      src_q      <= src_d;
      size_q     <= size_d;
      dt_q       <= dt_d;
      pay_q      <= pay_d;
      out_dst_q  <= out_dst_d;
      out_src_q  <= out_src_d;
      out_size_q <= out_size_d;
      out_dt_q   <= out_dt_d;
      out_pay_q  <= out_pay_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign o_dst          = out_dst_q;
  assign o_src          = out_src_q;
  assign o_size         = out_size_q;
  assign o_dir          = out_dt_q[7];
  assign o_type         = out_dt_q[6:0];
  assign o_payload      = out_pay_q;
  assign o_payload_size = out_size_q[5:0];
  assign o_valid        = valid_q;
  assign o_err          = err_q;
  assign o_err_code     = err_code_q;

endmodule

// File: tb/tb_frame_disassembly.sv
// Self-checking bench for frame_disassembly: frames are built by a small
// model, expected pulses are queued as bytes are driven and popped when the
// DUT pulses o_valid or o_err.
module tb_frame_disassembly;

  localparam int unsigned GapTimeout = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   i_rdata;
  logic         i_rvalid;
  logic [15:0]  o_dst, o_src, o_size;
  logic         o_dir;
  logic [6:0]   o_type;
  logic [335:0] o_payload;
  logic [5:0]   o_payload_size;
  logic         o_valid, o_err;
  logic [1:0]   o_err_code;

  frame_disassembly #(
    .GAP_TIMEOUT (GapTimeout)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_rdata        (i_rdata),
    .i_rvalid       (i_rvalid),
    .o_dst          (o_dst),
    .o_src          (o_src),
    .o_size         (o_size),
    .o_dir          (o_dir),
    .o_type         (o_type),
    .o_payload      (o_payload),
    .o_payload_size (o_payload_size),
    .o_valid        (o_valid),
    .o_err          (o_err),
    .o_err_code     (o_err_code)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         is_err;
    logic [1:0]   code;
    int unsigned  at;
    logic [15:0]  dst;
    logic [15:0]  src;
    logic [15:0]  size;
    logic [7:0]   dt;
    logic [335:0] pay;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: last good frame on the outputs and last error code
  logic [15:0]  good_dst, good_src, good_size;
  logic [7:0]   good_dt;
  logic [335:0] good_pay;
  logic [1:0]   last_code;
  int unsigned  last_drive;

  // Frame currently being built
  logic [7:0]   frame_q[$];
  logic [15:0]  cur_dst, cur_src, cur_size;
  logic [7:0]   cur_dt;
  logic [335:0] cur_pay;

  task automatic check_eq(input string tag, input logic [335:0] got, input logic [335:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_dst"}, o_dst, 0);
    check_eq({tag, "_src"}, o_src, 0);
    check_eq({tag, "_size"}, o_size, 0);
    check_eq({tag, "_dir"}, o_dir, 0);
    check_eq({tag, "_type"}, o_type, 0);
    check_eq({tag, "_payload"}, o_payload, 0);
    check_eq({tag, "_psize"}, o_payload_size, 0);
    check_eq({tag, "_valid"}, o_valid, 0);
    check_eq({tag, "_err"}, o_err, 0);
    check_eq({tag, "_code"}, o_err_code, 0);
  endtask

  task automatic reset_model();
    good_dst  = '0;
    good_src  = '0;
    good_size = '0;
    good_dt   = '0;
    good_pay  = '0;
    last_code = 2'd0;
  endtask

  task automatic load_frame0();
    frame_q  = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h00, 8'h85, 8'hF8, 8'h0A};
    cur_dst  = 16'h1234;
    cur_src  = 16'hABCD;
    cur_size = 16'h0000;
    cur_dt   = 8'h85;
    cur_pay  = '0;
  endtask

  task automatic make_frame(input logic [15:0] dst, input logic [15:0] src, input logic dir,
                            input logic [6:0] typ, input int n, input logic [7:0] base);
    logic [15:0] s;
    cur_dst  = dst;
    cur_src  = src;
    cur_size = 16'(n);
    cur_dt   = {dir, typ};
    cur_pay  = '0;
    frame_q.delete();
    frame_q.push_back(dst[7:0]);
    frame_q.push_back(dst[15:8]);
    frame_q.push_back(src[7:0]);
    frame_q.push_back(src[15:8]);
    frame_q.push_back(cur_size[15:8]);
    frame_q.push_back(cur_size[7:0]);
    frame_q.push_back(cur_dt);
    for (int i = 0; i < n; i++) begin
      frame_q.push_back(8'(base + 8'(i)));
      cur_pay[8*i +: 8] = 8'(base + 8'(i));
    end
    s = '0;
    for (int k = 0; k < frame_q.size(); k++) s = s + (16'(frame_q[k]) << (k % 4));
    frame_q.push_back(s[7:0]);
    frame_q.push_back(s[15:8]);
  endtask

  task automatic push_good();
    exp_t e;
    good_dst  = cur_dst;
    good_src  = cur_src;
    good_size = cur_size;
    good_dt   = cur_dt;
    good_pay  = cur_pay;
    e.is_err = 1'b0;
    e.code   = last_code;
    e.at     = last_drive + 1;
    e.dst    = good_dst;
    e.src    = good_src;
    e.size   = good_size;
    e.dt     = good_dt;
    e.pay    = good_pay;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    last_code = code;
    e.is_err = 1'b1;
    e.code   = code;
    e.at     = last_drive + 1;
    e.dst    = good_dst;
    e.src    = good_src;
    e.size   = good_size;
    e.dt     = good_dt;
    e.pay    = good_pay;
    exp_q.push_back(e);
  endtask

  task automatic send(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      i_rvalid   = 1'b1;
      i_rdata    = frame_q[i];
      last_drive = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_rvalid   = 1'b0;
      i_rdata    = 8'h00;
      last_drive = cyc;
    end
  endtask

  // Scoreboard: compare each pulse against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      check_eq("missing_pulse", cyc, e.at);
    end
    if (o_valid || o_err) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {o_valid, o_err, o_err_code}, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("pulse_kind", {o_valid, o_err}, e.is_err ? 2'b01 : 2'b10);
        check_eq("pulse_cycle", cyc, e.at);
        check_eq("err_code", o_err_code, e.code);
        check_eq("dst", o_dst, e.dst);
        check_eq("src", o_src, e.src);
        check_eq("size", o_size, e.size);
        check_eq("dir", o_dir, e.dt[7]);
        check_eq("type", o_type, e.dt[6:0]);
        check_eq("payload", o_payload, e.pay);
        check_eq("payload_size", o_payload_size, e.size[5:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    i_rvalid = 1'b0;
    i_rdata  = 8'h00;
    last_drive = 0;
    reset_model();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Reference zero-payload frame
    load_frame0();
    send(0, 8);
    push_good();
    idle(3);

    // Corrupted SCS high byte
    load_frame0();
    frame_q[8] = 8'h0B;
    send(0, 8);
`ifdef FRAME_DISASSEMBLY_SCS_CHECK_EN
    push_err(2'd1);
`else
    push_good();
`endif
    idle(3);

    // Maximum payload immediately followed by the zero-payload frame
    make_frame(16'h0102, 16'h0304, 1'b0, 7'h11, 42, 8'h00);
    send(0, frame_q.size() - 1);
    push_good();
    load_frame0();
    send(0, 8);
    push_good();
    idle(3);

    // Oversize: error at 7th byte, trailing bytes discarded until the gap
    load_frame0();
    frame_q[5] = 8'h2B;
    send(0, 6);
    push_err(2'd2);
    send(7, 8);
    idle(GapTimeout + 4);
    make_frame(16'h5A5A, 16'hA5A5, 1'b1, 7'h7F, 3, 8'hF0);
    send(0, frame_q.size() - 1);
    push_good();
    idle(2);

    // Short mid-payload gap is transparent
    make_frame(16'hBEEF, 16'hCAFE, 1'b0, 7'h2A, 12, 8'h40);
    send(0, 12);
    idle(5);
    send(13, frame_q.size() - 1);
    push_good();
    idle(2);

    // Gap timeout after byte 20, then recovery
    make_frame(16'h1111, 16'h2222, 1'b1, 7'h33, 42, 8'h80);
    send(0, 19);
    idle(GapTimeout);
    push_err(2'd3);
    idle(3);
    make_frame(16'h0F0F, 16'hF0F0, 1'b0, 7'h01, 1, 8'h99);
    send(0, frame_q.size() - 1);
    push_good();
    idle(2);

    // Random back-to-back frames
    for (int r = 0; r < 4; r++) begin
      make_frame(16'($urandom), 16'($urandom), 1'($urandom), 7'($urandom),
                 int'($urandom_range(0, 42)), 8'($urandom));
      send(0, frame_q.size() - 1);
      push_good();
    end
    idle(3);

    // Reset in the middle of a frame
    make_frame(16'h7777, 16'h8888, 1'b1, 7'h44, 10, 8'h10);
    send(0, 9);
    @(negedge clk);
    rst      = 1'b1;
    i_rvalid = 1'b0;
    @(negedge clk);
    check_zero("reset_midframe");
    rst = 1'b0;
    reset_model();
    last_drive = cyc;
    make_frame(16'h1357, 16'h2468, 1'b0, 7'h55, 5, 8'h20);
    send(0, frame_q.size() - 1);
    push_good();
    idle(5);

    check_eq("pending_expectations", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
